spi_pwm_expander: RTL and testbench

- SPI-controlled PWM I/O expander: an SPI slave (mode 0, write-only by default) receives an address byte followed by data bytes.
- Data bytes land in a byte-addressed register file of NUM_PWM identical 6-byte PWM channels.
- Each channel drives one PWM output timed from a separate system clock CLK, gated by EN.
- Top-level block between an external SPI master and the board's PWM pins.

---
 rtl/spi_pwm_expander.sv | 182 ++++++++++++++++++
 tb/tb_spi_pwm_expander.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_expander.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_pwm_expander
// Purpose  : SPI-written register file driving NUM_PWM shadowed PWM channels.
//            Optional MISO readback path enabled by macro SPI_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pwm_expander #(
    parameter int NUM_PWM = 4
) (
    input  logic               SCLK,
    input  logic               _RST,
    input  logic               CLK,
    input  logic               EN,
    input  logic               _CS,
    input  logic               MOSI,
    output logic               MISO,
    output logic [NUM_PWM-1:0] PWMOutputs
);

    localparam int NUM_REGS = 6 * NUM_PWM;

    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic       addr_loaded;
    logic [7:0] addr;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       wr_en;
    logic [7:0] regs  [NUM_REGS];
    logic [7:0] sync1 [NUM_REGS];
    logic [7:0] sync2 [NUM_REGS];

    assign rx_byte   = {shift_reg, MOSI};
    // bit_cnt is held at 0 while _CS is high, so byte_done implies an active frame
    assign byte_done = (bit_cnt == 3'd7);
    assign wr_en     = byte_done && addr_loaded;

    always_ff @(posedge SCLK or negedge _RST or posedge _CS) begin
        if (!_RST) begin
            bit_cnt     <= 3'd0;
            shift_reg   <= 7'd0;
            addr_loaded <= 1'b0;
        end else if (_CS) begin
            bit_cnt     <= 3'd0;
            shift_reg   <= 7'd0;
            addr_loaded <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            shift_reg <= rx_byte[6:0];
            if (byte_done) begin
                addr_loaded <= 1'b1;
            end
        end
    end

    always_ff @(posedge SCLK or negedge _RST) begin
        if (!_RST) begin
            addr <= 8'd0;
        end else if (byte_done) begin
            addr <= addr_loaded ? addr + 8'd1 : rx_byte;
        end
    end

    always_ff @(posedge SCLK or negedge _RST) begin
        if (!_RST) begin
            for (int j = 0; j < NUM_REGS; j++) begin
                regs[j] <= 8'd0;
            end
        end else if (wr_en) begin
            for (int j = 0; j < NUM_REGS; j++) begin
                if (addr == 8'(j)) begin
                    regs[j] <= rx_byte;
                end
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] rd_byte;

    always_comb begin
        rd_byte = 8'h00;
        for (int j = 0; j < NUM_REGS; j++) begin
            if (addr == 8'(j)) begin
                rd_byte = regs[j];
            end
        end
    end

    // Launched on the falling edge so the master samples a stable bit on the next rising edge
    always_ff @(negedge SCLK or negedge _RST or posedge _CS) begin
        if (!_RST) begin
            MISO <= 1'b0;
        end else if (_CS) begin
            MISO <= 1'b0;
        end else begin
            MISO <= addr_loaded ? rd_byte[3'd7 - bit_cnt] : 1'b0;
        end
    end
`else
    assign MISO = 1'b0;
`endif

    // Whole PWM domain, synchronisers included, advances only on enabled CLK edges
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            for (int j = 0; j < NUM_REGS; j++) begin
                sync1[j] <= 8'd0;
                sync2[j] <= 8'd0;
            end
        end else if (EN) begin
            for (int j = 0; j < NUM_REGS; j++) begin
                sync1[j] <= regs[j];
                sync2[j] <= sync1[j];
            end
        end
    end

    for (genvar i = 0; i < NUM_PWM; i++) begin : g_ch
        localparam int B = 6 * i;

        logic [15:0] period_new;
        logic [15:0] duty_new;
        logic [7:0]  presc_new;
        logic        ch_en;
        logic        inv;
        logic [15:0] period_act;
        logic [15:0] duty_act;
        logic [7:0]  presc_act;
        logic [15:0] cnt;
        logic [7:0]  presc_cnt;
        logic        en_d;

        assign period_new = {sync2[B], sync2[B+1]};
        assign duty_new   = {sync2[B+2], sync2[B+3]};
        assign presc_new  = sync2[B+4];
        assign ch_en      = sync2[B+5][0];
        assign inv        = sync2[B+5][1];

        always_ff @(posedge CLK or negedge _RST) begin
            if (!_RST) begin
                period_act <= 16'd0;
                duty_act   <= 16'd0;
                presc_act  <= 8'd0;
                cnt        <= 16'd0;
                presc_cnt  <= 8'd0;
                en_d       <= 1'b0;
            end else if (EN) begin
                en_d <= ch_en;
                if (!ch_en) begin
                    cnt       <= 16'd0;
                    presc_cnt <= 8'd0;
                end else if (!en_d) begin
                    cnt        <= 16'd0;
                    presc_cnt  <= 8'd0;
                    period_act <= period_new;
                    duty_act   <= duty_new;
                    presc_act  <= presc_new;
                end else if (presc_cnt == presc_act) begin
                    presc_cnt <= 8'd0;
                    if (cnt == period_act) begin
                        cnt        <= 16'd0;
                        period_act <= period_new;
                        duty_act   <= duty_new;
                        presc_act  <= presc_new;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end else begin
                    presc_cnt <= presc_cnt + 8'd1;
                end
            end
        end

        // en_d gates the output so it only uses shadows that have been loaded
        assign PWMOutputs[i] = en_d & ((cnt < duty_act) ^ inv);
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_pwm_expander.sv
`timescale 1ns/1ps
`default_nettype none
// Randomised self-checking bench for spi_pwm_expander against a register/PWM model.
module tb_spi_pwm_expander;

    localparam int NUM_PWM = 4;
    localparam int NREG    = 6 * NUM_PWM;

    logic               SCLK = 1'b0;
    logic               _RST = 1'b0;
    logic               CLK  = 1'b0;
    logic               EN   = 1'b1;
    logic               _CS  = 1'b1;
    logic               MOSI = 1'b0;
    logic               MISO;
    logic [NUM_PWM-1:0] PWMOutputs;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [7:0] model [256];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    spi_pwm_expander #(.NUM_PWM(NUM_PWM)) dut (
        .SCLK       (SCLK),
        ._RST       (_RST),
        .CLK        (CLK),
        .EN         (EN),
        ._CS        (_CS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .PWMOutputs (PWMOutputs)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic out_of(input int ch);
        logic [31:0] t;
        t = 32'(PWMOutputs) >> ch;
        return t[0];
    endfunction

    function automatic logic [7:0] rb_expect(input logic [7:0] a);
`ifdef SPI_READBACK_EN
        return (int'(a) < NREG) ? model[a] : 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    // Steady-state PWM of a channel: period length and high cycles per period
    function automatic void model_ch(input int ch, output int per, output int highs);
        logic [7:0] b;
        int period, duty, presc, raw;
        b      = 8'(6 * ch);
        period = int'({model[b], model[b + 8'd1]});
        duty   = int'({model[b + 8'd2], model[b + 8'd3]});
        presc  = int'(model[b + 8'd4]);
        per    = (period + 1) * (presc + 1);
        raw    = ((duty > period) ? period + 1 : duty) * (presc + 1);
        if (!model[b + 8'd5][0]) highs = 0;
        else if (model[b + 8'd5][1]) highs = per - raw;
        else highs = raw;
    endfunction

    task automatic clear_model();
        for (int j = 0; j < 256; j++) model[j] = 8'h00;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        MOSI = b;
        #20;
        m = MISO;
        SCLK = 1'b1;
        #20;
        SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int k = 7; k >= 0; k--) begin
            spi_bit(tx[k], m);
            rx[k] = m;
        end
    endtask

    task automatic spi_frame(input logic [7:0] start);
        logic [7:0] a, rx;
        rx_q.delete();
        exp_q.delete();
        if (_CS) begin
            _CS = 1'b0;
            #20;
        end
        spi_byte(start, rx);
        rx_q.push_back(rx);
        exp_q.push_back(8'h00);
        a = start;
        foreach (tx_q[k]) begin
            exp_q.push_back(rb_expect(a));
            spi_byte(tx_q[k], rx);
            rx_q.push_back(rx);
            if (int'(a) < NREG) model[a] = tx_q[k];
            a = a + 8'd1;
        end
        #20;
        _CS = 1'b1;
        #40;
    endtask

    task automatic count_high(input int ch, input int cycles, output int h);
        h = 0;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
            h += int'(out_of(ch));
        end
    endtask

    task automatic find_rise(input int ch, input int budget, output int t, output logic ok);
        logic prev, cur;
        ok   = 1'b0;
        t    = 0;
        prev = out_of(ch);
        for (int k = 0; k < budget; k++) begin
            @(posedge CLK);
            #1;
            cur = out_of(ch);
            if (!prev && cur) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
            prev = cur;
        end
    endtask

    task automatic rand_cfg();
        int per, presc, duty;
        logic [7:0] dhi, ctrl;
        per   = $urandom_range(0, 15);
        presc = $urandom_range(0, 3);
        duty  = $urandom_range(0, per + 2);
        dhi   = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
        ctrl  = {6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b1};
        tx_q  = {8'h00, 8'(per), dhi, 8'(duty), 8'(presc), ctrl};
    endtask

    task automatic test_reset();
        logic m;
        _RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (PWMOutputs !== '0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", PWMOutputs); end
        n_cmp++;
        if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", MISO); end
        _RST = 1'b1;
        #30;
        _CS = 1'b0;
        #20;
        for (int k = 0; k < 3; k++) spi_bit(1'b1, m);
        _RST = 1'b0;
        #30;
        n_cmp++;
        if (PWMOutputs !== '0 || MISO !== 1'b0)
            begin n_fail++; $display("FAIL reset_midbyte: pwm %b miso %b want 0 0", PWMOutputs, MISO); end
        _RST = 1'b1;
        #30;
        clear_model();
    endtask

    // Continues the frame left open by test_reset: the partial byte must be gone
    task automatic test_ch0_basic();
        int per, exp_h, got, t0, t1;
        logic ok0, ok1;
        tx_q = {8'h00, 8'h09, 8'h00, 8'h03, 8'h00, 8'h01};
        spi_frame(8'h00);
        foreach (rx_q[k]) begin
            n_cmp++;
            if (rx_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL ch0_miso_byte%0d: got %02h want %02h", k, rx_q[k], exp_q[k]); end
        end
        repeat (30) @(posedge CLK);
        count_high(0, 100, got);
        n_cmp++;
        if (got !== 30) begin n_fail++; $display("FAIL ch0_duty: high %0d want 30 of 100", got); end
        find_rise(0, 50, t0, ok0);
        find_rise(0, 50, t1, ok1);
        n_cmp++;
        if (!ok0 || !ok1 || (t1 - t0) !== 10)
            begin n_fail++; $display("FAIL ch0_period: got %0d cycles (found %b%b) want 10", t1 - t0, ok0, ok1); end
        for (int c = 0; c < NUM_PWM; c++) begin
            model_ch(c, per, exp_h);
            count_high(c, 2 * per, got);
            n_cmp++;
            if (got !== 2 * exp_h)
                begin n_fail++; $display("FAIL ch0_basic_ch%0d: high %0d want %0d", c, got, 2 * exp_h); end
        end
    endtask

    task automatic test_ch1_inv();
        int per, exp_h, got;
        tx_q = {8'h00, 8'h04, 8'h00, 8'h05, 8'h01, 8'h03};
        spi_frame(8'h06);
        foreach (rx_q[k]) begin
            n_cmp++;
            if (rx_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL ch1_miso_byte%0d: got %02h want %02h", k, rx_q[k], exp_q[k]); end
        end
        repeat (30) @(posedge CLK);
        count_high(1, 40, got);
        n_cmp++;
        if (got !== 0) begin n_fail++; $display("FAIL ch1_inv_low: high %0d want 0", got); end
        for (int c = 0; c < NUM_PWM; c++) begin
            model_ch(c, per, exp_h);
            count_high(c, 2 * per, got);
            n_cmp++;
            if (got !== 2 * exp_h)
                begin n_fail++; $display("FAIL ch1_inv_ch%0d: high %0d want %0d", c, got, 2 * exp_h); end
        end
    endtask

    task automatic test_midperiod_duty();
        int t0, got;
        logic ok;
        tx_q = {8'd39};
        spi_frame(8'h04);
        repeat (60) @(posedge CLK);
        find_rise(0, 1000, t0, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL mid_find_rise: got timeout want rising edge"); end
        tx_q = {8'h00};
        spi_frame(8'h03);
        while (cyc < t0 + 100) @(posedge CLK);
        #1;
        n_cmp++;
        if (out_of(0) !== 1'b1) begin n_fail++; $display("FAIL mid_duty_deferred: got %b want 1", out_of(0)); end
        while (cyc < t0 + 410) @(posedge CLK);
        count_high(0, 400, got);
        n_cmp++;
        if (got !== 0) begin n_fail++; $display("FAIL mid_duty_zero: high %0d want 0", got); end
        tx_q = {8'h03, 8'h00};
        spi_frame(8'h03);
        foreach (rx_q[k]) begin
            n_cmp++;
            if (rx_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL mid_miso_byte%0d: got %02h want %02h", k, rx_q[k], exp_q[k]); end
        end
        repeat (450) @(posedge CLK);
    endtask

    task automatic test_cs_abort();
        logic [7:0] rx;
        logic m;
        int per, exp_h, got;
        _CS = 1'b0;
        #20;
        spi_byte(8'h17, rx);
        for (int k = 0; k < 5; k++) spi_bit(1'b1, m);
        _CS = 1'b1;
        #40;
        repeat (10) @(posedge CLK);
        count_high(3, 50, got);
        n_cmp++;
        if (got !== 0) begin n_fail++; $display("FAIL abort_no_write: ch3 high %0d want 0", got); end
        tx_q = {8'h00, 8'h07, 8'h00, 8'h02, 8'h00, 8'h01};
        spi_frame(8'h12);
        foreach (rx_q[k]) begin
            n_cmp++;
            if (rx_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL abort_miso_byte%0d: got %02h want %02h", k, rx_q[k], exp_q[k]); end
        end
        repeat (30) @(posedge CLK);
        for (int c = 0; c < NUM_PWM; c++) begin
            model_ch(c, per, exp_h);
            count_high(c, 2 * per, got);
            n_cmp++;
            if (got !== 2 * exp_h)
                begin n_fail++; $display("FAIL abort_ch%0d: high %0d want %0d", c, got, 2 * exp_h); end
        end
    endtask

    task automatic test_en_freeze();
        int sq[$];
        int v, sum, per, exp_h, got;
        logic snap;
        for (int i = 0; i < 90; i++) begin
            @(negedge CLK);
            EN = (i >= 30 && i < 50) ? 1'b0 : 1'b1;
            @(posedge CLK);
            #1;
            v = int'(out_of(0));
            if (EN) sq.push_back(v);
            else begin
                n_cmp++;
                if (v !== sq[sq.size() - 1])
                    begin n_fail++; $display("FAIL en_hold_%0d: got %0d want %0d", i, v, sq[sq.size() - 1]); end
            end
        end
        sum = 0;
        for (int n = 0; n < 10; n++) sum += sq[n];
        n_cmp++;
        if (sum !== 3) begin n_fail++; $display("FAIL en_duty: high %0d want 3 of 10", sum); end
        for (int n = 10; n < sq.size(); n++) begin
            n_cmp++;
            if (sq[n] !== sq[n - 10])
                begin n_fail++; $display("FAIL en_resume_%0d: got %0d want %0d", n, sq[n], sq[n - 10]); end
        end
        @(negedge CLK);
        EN = 1'b0;
        @(posedge CLK);
        #1;
        snap = out_of(0);
        rand_cfg();
        spi_frame(8'h0C);
        foreach (rx_q[k]) begin
            n_cmp++;
            if (rx_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL en_wr_miso_byte%0d: got %02h want %02h", k, rx_q[k], exp_q[k]); end
        end
        for (int k = 0; k < 6; k++) tx_q[k] = model[8'(12 + k)];
        spi_frame(8'h0C);
        foreach (rx_q[k]) begin
            n_cmp++;
            if (rx_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL en_rb_miso_byte%0d: got %02h want %02h", k, rx_q[k], exp_q[k]); end
        end
        n_cmp++;
        if (out_of(0) !== snap) begin n_fail++; $display("FAIL en_hold_spi: got %b want %b", out_of(0), snap); end
        @(negedge CLK);
        EN = 1'b1;
        repeat (40) @(posedge CLK);
        for (int c = 0; c < NUM_PWM; c++) begin
            model_ch(c, per, exp_h);
            count_high(c, 2 * per, got);
            n_cmp++;
            if (got !== 2 * exp_h)
                begin n_fail++; $display("FAIL en_spi_ch%0d: high %0d want %0d", c, got, 2 * exp_h); end
        end
    endtask

    task automatic test_random();
        int c, per, exp_h, got;
        for (int it = 0; it < 6; it++) begin
            c = $urandom_range(0, NUM_PWM - 1);
            tx_q = {8'h00};
            spi_frame(8'(6 * c + 5));
            rand_cfg();
            spi_frame(8'(6 * c));
            foreach (rx_q[k]) begin
                n_cmp++;
                if (rx_q[k] !== exp_q[k])
                    begin n_fail++; $display("FAIL rand%0d_miso_byte%0d: got %02h want %02h", it, k, rx_q[k], exp_q[k]); end
            end
            repeat (30) @(posedge CLK);
            for (int ch = 0; ch < NUM_PWM; ch++) begin
                model_ch(ch, per, exp_h);
                count_high(ch, 2 * per, got);
                n_cmp++;
                if (got !== 2 * exp_h)
                    begin n_fail++; $display("FAIL rand%0d_ch%0d: high %0d want %0d", it, ch, got, 2 * exp_h); end
            end
        end
    endtask

    task automatic test_addr_wrap();
        int per, exp_h, got;
        tx_q = {8'($urandom), 8'($urandom), 8'h00, 8'h0B};
        spi_frame(8'hFE);
        foreach (rx_q[k]) begin
            n_cmp++;
            if (rx_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL wrap_miso_byte%0d: got %02h want %02h", k, rx_q[k], exp_q[k]); end
        end
        tx_q = {8'hAA, 8'h55};
        spi_frame(8'(NREG));
        foreach (rx_q[k]) begin
            n_cmp++;
            if (rx_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL oor_miso_byte%0d: got %02h want %02h", k, rx_q[k], exp_q[k]); end
        end
        repeat (150) @(posedge CLK);
        for (int c = 0; c < NUM_PWM; c++) begin
            model_ch(c, per, exp_h);
            count_high(c, 2 * per, got);
            n_cmp++;
            if (got !== 2 * exp_h)
                begin n_fail++; $display("FAIL wrap_ch%0d: high %0d want %0d", c, got, 2 * exp_h); end
        end
    endtask

    task automatic test_reset_clears();
        int bad;
        _RST = 1'b0;
        #30;
        n_cmp++;
        if (PWMOutputs !== '0) begin n_fail++; $display("FAIL rst_run_pwm: got %b want 0", PWMOutputs); end
        _RST = 1'b1;
        clear_model();
        repeat (60) @(posedge CLK);
        bad = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (PWMOutputs !== '0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("FAIL rst_regs_cleared: %0d active cycles want 0", bad); end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_ch0_basic();
        test_ch1_inv();
        test_midperiod_duty();
        test_cs_abort();
        test_en_freeze();
        test_random();
        test_addr_wrap();
        test_reset_clears();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
